// File: rtl/eth_pkg.sv
// Shared constants and FSM encoding for the 10BASE-T MAC transmit framer.
package eth_pkg;
  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam int          PREAMBLE_LEN = 7;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_SFD      = 3'd2;
  localparam logic [2:0] ST_PAYLOAD  = 3'd3;
  localparam logic [2:0] ST_PAD      = 3'd4;
  localparam logic [2:0] ST_FCS      = 3'd5;
  localparam logic [2:0] ST_IFG      = 3'd6;
endpackage

// File: rtl/eth_tx_framer_if.sv
// Byte streams around the framer: raw frame in (s_*), wire frame out (m_*).
interface eth_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_first;
  logic       m_last;
  logic       m_ready;

  modport master (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_first, m_last
  );
  modport slave (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_first, m_last
  );
endinterface

// File: rtl/eth_crc32.sv
// Byte-wide next-state function of the reflected Ethernet CRC-32 (LSB first).
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end
endmodule

// File: rtl/eth_tx_framer.sv
// MAC transmit framer: preamble/SFD, payload, zero pad to MIN_LEN, FCS, then IFG.
// Output register advances only when empty or accepted by the serializer.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514,
  parameter int IFG_CYCLES = 192
) (
  input  logic            clk,
  input  logic            rst,
  eth_tx_framer_if.master bus,
  output logic            tx_busy,
  output logic            err_oversize
);
  // One counter serves preamble, payload length (saturating at MAX_LEN+1), FCS index and IFG.
  localparam int CNT_TOP = (MAX_LEN + 1 > IFG_CYCLES) ? MAX_LEN + 1 : IFG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]      crc_q, crc_d, crc_nxt, fcs;
  logic [7:0]       crc_byte;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d, first_q, first_d, last_q, last_d, err_q, err_d;
  logic             adv, full, s_hs;

  assign adv         = !valid_q || bus.m_ready;
  assign full        = cnt_q >= MAX_C;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign bus.s_ready = (state_q == ST_PAYLOAD) && (full || adv);
  assign s_hs        = bus.s_valid && bus.s_ready;
  assign crc_byte    = (state_q == ST_PAD) ? 8'h00 : bus.s_data;
  assign fcs         = ~crc_q;

  eth_crc32 u_crc (
    .crc_in  (crc_q),
    .data    (crc_byte),
    .crc_out (crc_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    data_d  = data_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.s_valid && adv) begin
          data_d  = ETH_PREAMBLE;
          valid_d = 1'b1;
          first_d = 1'b1;
          last_d  = 1'b0;
          cnt_d   = CNT_W'(1);
          state_d = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (adv) begin
          data_d  = ETH_PREAMBLE;
          first_d = 1'b0;
          cnt_d   = cnt_inc;
          if (cnt_q == PRE_LAST) state_d = ST_SFD;
        end
      end
      ST_SFD: begin
        if (adv) begin
          data_d  = ETH_SFD;
          crc_d   = CRC32_INIT;
          cnt_d   = '0;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (s_hs && !full) begin
          data_d  = bus.s_data;
          valid_d = 1'b1;
          crc_d   = crc_nxt;
          cnt_d   = cnt_inc;
          if (bus.s_last) begin
            state_d = (cnt_inc < MIN_C) ? ST_PAD : ST_FCS;
            if (cnt_inc >= MIN_C) cnt_d = '0;
          end
        end else begin
          // Oversize bytes are swallowed; the output register just drains meanwhile.
          if (s_hs) begin
            err_d = (cnt_q == MAX_C);
            if (cnt_q == MAX_C) cnt_d = cnt_inc;
            if (bus.s_last) begin
              state_d = ST_FCS;
              cnt_d   = '0;
            end
          end
          if (adv) valid_d = 1'b0;
        end
      end
      ST_PAD: begin
        if (adv) begin
          data_d  = 8'h00;
          valid_d = 1'b1;
          crc_d   = crc_nxt;
          cnt_d   = cnt_inc;
          if (cnt_inc == MIN_C) begin
            state_d = ST_FCS;
            cnt_d   = '0;
          end
        end
      end
      ST_FCS: begin
        if (adv) begin
          if (cnt_q == CNT_W'(4)) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_IFG;
          end else begin
            data_d  = fcs[{cnt_q[1:0], 3'b000} +: 8];
            valid_d = 1'b1;
            last_d  = (cnt_q == CNT_W'(3));
            cnt_d   = cnt_inc;
          end
        end
      end
      ST_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      crc_q   <= CRC32_INIT;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.m_data    = data_q;
  assign bus.m_valid   = valid_q;
  assign bus.m_first   = first_q;
  assign bus.m_last    = last_q;
  assign tx_busy       = (state_q != ST_IDLE);
  assign err_oversize  = err_q;
endmodule

// File: tb/tb_eth_tx_framer.sv
// Randomized bench for eth_tx_framer: default instance plus a MIN_LEN=9/MAX_LEN=20 instance.
module tb_eth_tx_framer;
  localparam int IFG = 192;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] s_data;
  logic       s_valid, s_last, m_ready, sel;
  logic       busy_a, busy_b, err_a, err_b;

  eth_tx_framer_if ifa ();
  eth_tx_framer_if ifb ();

  assign ifa.s_data  = s_data;
  assign ifa.s_valid = s_valid;
  assign ifa.s_last  = s_last;
  assign ifa.m_ready = m_ready;
  assign ifb.s_data  = s_data;
  assign ifb.s_valid = s_valid;
  assign ifb.s_last  = s_last;
  assign ifb.m_ready = m_ready;

  eth_tx_framer #(.MIN_LEN(60), .MAX_LEN(1514), .IFG_CYCLES(IFG)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.master), .tx_busy(busy_a), .err_oversize(err_a));
  eth_tx_framer #(.MIN_LEN(9), .MAX_LEN(20), .IFG_CYCLES(IFG)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.master), .tx_busy(busy_b), .err_oversize(err_b));

  logic [7:0] m_data;
  logic       m_valid, m_first, m_last, s_ready, tx_busy, err_o;
  assign m_data  = sel ? ifb.m_data  : ifa.m_data;
  assign m_valid = sel ? ifb.m_valid : ifa.m_valid;
  assign m_first = sel ? ifb.m_first : ifa.m_first;
  assign m_last  = sel ? ifb.m_last  : ifa.m_last;
  assign s_ready = sel ? ifb.s_ready : ifa.s_ready;
  assign tx_busy = sel ? busy_b      : busy_a;
  assign err_o   = sel ? err_b       : err_a;

  int n_vec, n_mis;
  logic [7:0] pay_q[$], pay2_q[$], exp_q[$], got_q[$];
  int first_pos, n_first, last_pos, n_last, stall_viol, err_cnt, err_at, span, quiet, gap;
  bit aborted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Reference wire frame straight from the framing rules.
  function automatic void build_exp(input int min_len, input int max_len);
    logic [7:0]  body[$];
    logic [31:0] crc;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < pay_q.size() && i < max_len; i++) body.push_back(pay_q[i]);
    while (body.size() < min_len) body.push_back(8'h00);
    crc = 32'hFFFFFFFF;
    foreach (body[i])
      for (int b = 0; b < 8; b++)
        crc = (crc >> 1) ^ (((crc[0] ^ body[i][b]) != 1'b0) ? 32'hEDB88320 : 32'h0);
    crc = ~crc;
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
  endfunction

  task automatic gen(input int n);
    pay_q.delete();
    repeat (n) pay_q.push_back(8'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0: m_ready high, s_valid continuous; mode 1: m_ready 1-in-16 with random stalls and underruns.
  task automatic run_frame(input int mode, input int rst_at, input bit hold, input logic [7:0] nxt);
    int  idx, cyc, hs_first, hs_last;
    bit  done, pstall, stop;
    logic [7:0] pdata;
    logic pfirst, plast;
    got_q.delete();
    n_first = 0; first_pos = -1; n_last = 0; last_pos = -1;
    stall_viol = 0; err_cnt = 0; err_at = -1; aborted = 0;
    idx = 0; cyc = 0; done = 0; pstall = 0; hs_first = -1; hs_last = -1;
    pdata = 8'h00; pfirst = 1'b0; plast = 1'b0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      s_valid = (idx < pay_q.size()) && (mode == 0 || $urandom_range(7) != 0);
      s_data  = (idx < pay_q.size()) ? pay_q[idx] : 8'h00;
      s_last  = (idx == pay_q.size() - 1);
      m_ready = (mode == 0) ? 1'b1 : ((cyc % 16 == 0) && ($urandom_range(3) != 0));
      #1;
      if (rst_at >= 0 && idx == rst_at) begin
        check("busy_before_rst", tx_busy, 1);
        rst = 1'b1; s_valid = 1'b0;
        @(negedge clk); #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_tx_busy", tx_busy, 0);
        rst = 1'b0;
        aborted = 1;
        return;
      end
      if (pstall && (m_data !== pdata || m_valid !== 1'b1 || m_first !== pfirst || m_last !== plast))
        stall_viol++;
      if (err_o) begin
        err_cnt++;
        if (err_at < 0) err_at = idx;
      end
      if (s_valid && s_ready) idx++;
      if (m_valid && m_ready) begin
        if (m_first) begin
          n_first++;
          if (first_pos < 0) first_pos = got_q.size();
        end
        if (m_last) begin
          n_last++;
          last_pos = got_q.size();
          done = 1;
        end
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
        got_q.push_back(m_data);
      end
      pstall = m_valid && !m_ready;
      pdata = m_data; pfirst = m_first; plast = m_last;
      cyc++;
    end
    check("frame_done", done, 1);
    span = hs_last - hs_first;
    quiet = 0; gap = -1; stop = 0;
    for (int k = 1; k <= IFG + 10 && !stop; k++) begin
      @(negedge clk);
      s_valid = hold; s_data = nxt; s_last = 1'b0; m_ready = 1'b0;
      #1;
      if (hold) begin
        if (m_valid && m_first) begin
          gap = k - 1;
          stop = 1;
        end
      end else if (!tx_busy) begin
        stop = 1;
      end else if (!m_valid && !s_ready) begin
        quiet++;
      end
    end
  endtask

  task automatic verify_frame(input string tag, input int min_len, input int max_len, input bit contig);
    build_exp(min_len, max_len);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_first_pos"}, first_pos, 0);
    check({tag, "_n_first"}, n_first, 1);
    check({tag, "_last_pos"}, last_pos, exp_q.size() - 1);
    check({tag, "_n_last"}, n_last, 1);
    check({tag, "_stall_hold"}, stall_viol, 0);
    if (contig) check({tag, "_contig"}, span, exp_q.size() - 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_vec = 0; n_mis = 0;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid0", m_valid, 0);
    check("rst_m_first0", m_first, 0);
    check("rst_m_last0", m_last, 0);
    check("rst_m_data0", m_data, 8'h00);
    check("rst_s_ready0", s_ready, 0);
    check("rst_tx_busy0", tx_busy, 0);
    check("rst_err0", err_o, 0);
    rst = 1'b0;

    // Known-answer CRC vector on the short-minimum instance.
    sel = 1'b1; do_reset();
    pay_q.delete();
    for (int i = 0; i < 9; i++) pay_q.push_back(8'h31 + 8'(i));
    run_frame(0, -1, 0, 8'h00);
    verify_frame("kat", 9, 20, 1);
    if (got_q.size() >= 4) begin
      check("kat_fcs0", got_q[got_q.size()-4], 8'h26);
      check("kat_fcs1", got_q[got_q.size()-3], 8'h39);
      check("kat_fcs2", got_q[got_q.size()-2], 8'hF4);
      check("kat_fcs3", got_q[got_q.size()-1], 8'hCB);
    end else begin
      check("kat_fcs_present", got_q.size(), 4);
    end
    check("kat_ifg_quiet", quiet, IFG);

    // Short frame padded to 60, unstalled then stalled.
    sel = 1'b0; do_reset();
    gen(14);
    run_frame(0, -1, 0, 8'h00);
    verify_frame("pad14", 60, 1514, 1);
    check("pad14_ifg_quiet", quiet, IFG);
    run_frame(1, -1, 0, 8'h00);
    verify_frame("pad14_stall", 60, 1514, 0);

    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(80, 1);
      gen(n);
      run_frame(f % 2, -1, 0, 8'h00);
      verify_frame($sformatf("rnd_a%0d", f), 60, 1514, (f % 2) == 0);
    end

    sel = 1'b1; do_reset();
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(30, 1);
      gen(n);
      run_frame(f % 2, -1, 0, 8'h00);
      verify_frame($sformatf("rnd_b%0d", f), 9, 20, ((f % 2) == 0) && n <= 20);
      check($sformatf("rnd_b%0d_err", f), err_cnt, (n > 20) ? 1 : 0);
    end

    // Oversize: 25 bytes against MAX_LEN=20, then exactly 20.
    gen(25);
    run_frame(0, -1, 0, 8'h00);
    verify_frame("over25", 9, 20, 0);
    check("over25_err_cnt", err_cnt, 1);
    check("over25_err_at", err_at, 21);
    gen(20);
    run_frame(0, -1, 0, 8'h00);
    verify_frame("exact20", 9, 20, 1);
    check("exact20_err_cnt", err_cnt, 0);

    // Reset in the middle of the payload, then a clean frame.
    sel = 1'b0; do_reset();
    gen(20);
    run_frame(0, 10, 0, 8'h00);
    check("rst_aborted", aborted, 1);
    gen(30);
    run_frame(0, -1, 0, 8'h00);
    verify_frame("after_rst", 60, 1514, 1);

    // Back-to-back frames with s_valid held across the gap.
    gen(12);
    pay2_q = pay_q;
    gen(10);
    run_frame(0, -1, 1, pay2_q[0]);
    verify_frame("b2b_1", 60, 1514, 1);
    check("b2b_gap", gap, IFG + 1);
    pay_q = pay2_q;
    run_frame(0, -1, 0, 8'h00);
    verify_frame("b2b_2", 60, 1514, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
